// File: rtl/spi_pkg.sv
// Shared SPI definitions: responder FSM states and the bus mode used by
// both this responder and the master driver.
package spi_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } spi_state_e;

  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one SPI pin with rise/fall detection on the
// synchronized level.
module spi_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_dly;
  logic [STAGES:0]   r_fill;
  logic              w_armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_dly  <= RST_VAL;
      r_fill <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_dly  <= r_sync[STAGES-1];
      r_fill <= {r_fill[STAGES-1:0], 1'b1};
    end
  end

  // Edges are masked until the chain holds real pin samples, so the step
  // from the reset value to the live pin level is not reported as an edge.
  always_comb begin
    w_armed = r_fill[STAGES];
    o_level = r_sync[STAGES-1];
    o_rise  = w_armed &  r_sync[STAGES-1] & ~r_dly;
    o_fall  = w_armed & ~r_sync[STAGES-1] &  r_dly;
  end

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 responder: oversampled pins, one word per DATA_WIDTH clocks,
// one-entry transmit buffer with valid/ready and a receive strobe.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SPI_CLK,
  input  logic                  SPI_EN,
  input  logic                  SPI_MOSI,
  output logic                  SPI_MISO,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  tx_underrun
);

  localparam int unsigned     CW   = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(DATA_WIDTH - 1);

  logic w_sclk_level, w_sclk_rise, w_sclk_fall;
  logic w_en_level, w_en_rise, w_en_fall;
  logic w_mosi_level, w_mosi_rise_unused, w_mosi_fall_unused;
  logic w_sample, w_launch, w_wr, w_load;
  logic [DATA_WIDTH-1:0] w_rx_next;

  spi_state_e            r_state;
  logic                  r_miso;
  logic [CW-1:0]         r_bit_cnt;
  logic                  r_wrap;
  logic [DATA_WIDTH-2:0] r_shift_tx;
  logic [DATA_WIDTH-2:0] r_shift_rx;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_underrun;
  logic [DATA_WIDTH-1:0] r_buf;
  logic                  r_full;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .clk(clk), .rst(rst), .i_d(SPI_CLK),
    .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_en (
    .clk(clk), .rst(rst), .i_d(SPI_EN),
    .o_level(w_en_level), .o_rise(w_en_rise), .o_fall(w_en_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .i_d(SPI_MOSI),
    .o_level(w_mosi_level), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
  );

  always_comb begin
    w_sample  = (SPI_CPOL ^ SPI_CPHA) ? w_sclk_fall : w_sclk_rise;
    w_launch  = (SPI_CPOL ^ SPI_CPHA) ? w_sclk_rise : w_sclk_fall;
    w_wr      = tx_valid & ~r_full;
    w_rx_next = {r_shift_rx, w_mosi_level};
    // r_wrap marks that the last bit of a word was sampled; the following
    // launch edge starts the next word unless the frame is ending.
    w_load    = ((r_state == IDLE) && w_en_fall) ||
                ((r_state == SHIFT) && !w_en_rise && w_launch && r_wrap);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_miso     <= 1'b0;
      r_bit_cnt  <= '0;
      r_wrap     <= 1'b0;
      r_shift_tx <= '0;
      r_shift_rx <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_buf      <= '0;
      r_full     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      if (w_wr) r_buf <= tx_data;
      r_full <= w_wr | (r_full & ~w_load);

      if (w_load) begin
        r_state   <= SHIFT;
        r_bit_cnt <= '0;
        r_wrap    <= 1'b0;
        if (r_full) begin
          r_miso     <= r_buf[DATA_WIDTH-1];
          r_shift_tx <= r_buf[DATA_WIDTH-2:0];
        end else begin
          r_miso     <= 1'b0;
          r_shift_tx <= '0;
          r_underrun <= 1'b1;
        end
      end else if (r_state == SHIFT) begin
        if (w_en_rise) begin
          r_state   <= IDLE;
          r_miso    <= 1'b0;
          r_bit_cnt <= '0;
          r_wrap    <= 1'b0;
        end else if (w_sample) begin
          r_shift_rx <= w_rx_next[DATA_WIDTH-2:0];
          if (r_bit_cnt == LAST) begin
            r_bit_cnt  <= '0;
            r_wrap     <= 1'b1;
            r_rx_data  <= w_rx_next;
            r_rx_valid <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end else if (w_launch) begin
          r_miso     <= r_shift_tx[DATA_WIDTH-2];
          r_shift_tx <= r_shift_tx << 1;
        end
      end
    end
  end

  assign SPI_MISO    = r_miso;
  assign tx_ready    = ~r_full;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign busy        = ~w_en_level;
  assign tx_underrun = r_underrun;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed and randomized frames against a word-level model of the responder.
module tb_spi_peripheral;

  localparam int DW = 8;
  localparam int SS = 2;
  localparam int H  = SS + 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          SPI_CLK, SPI_EN, SPI_MOSI, SPI_MISO;
  logic [DW-1:0] tx_data;
  logic          tx_valid, tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid, busy, tx_underrun;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model_txq[$];
  logic [DW-1:0] rx_seen[$];
  int            n_under   = 0;
  int            exp_under = 0;
  logic [DW-1:0] mosi_w[4];
  logic [DW-1:0] miso_w[4];
  logic [DW-1:0] exp_w[4];

  always #5 clk = ~clk;

  spi_peripheral #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst),
    .SPI_CLK(SPI_CLK), .SPI_EN(SPI_EN), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .tx_underrun(tx_underrun)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) rx_seen.push_back(rx_data);
      if (tx_underrun) n_under++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ncyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [DW-1:0] v);
    int t = 0;
    while (!tx_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("tx_ready_wait", tx_ready, 1);
    tx_data  = v;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    model_txq.push_back(v);
  endtask

  // Each word start takes the buffered word, or zeros plus an underrun.
  function automatic logic [DW-1:0] model_next();
    if (model_txq.size() > 0) return model_txq.pop_front();
    exp_under++;
    return '0;
  endfunction

  task automatic frame(input int nw, input int abort_rises);
    int  rises = 0;
    bit  stop  = 0;
    SPI_MOSI = mosi_w[0][DW-1];
    SPI_EN   = 1'b0;
    for (int w = 0; w < nw; w++) begin
      exp_w[w] = model_next();
      for (int b = 0; b < DW; b++) begin
        SPI_MOSI = mosi_w[w][DW-1-b];
        ncyc(H);
        miso_w[w][DW-1-b] = SPI_MISO;
        SPI_CLK = 1'b1;
        rises++;
        ncyc(H);
        SPI_CLK = 1'b0;
        if ((w == nw-1 && b == DW-1) || (abort_rises > 0 && rises == abort_rises)) begin
          SPI_EN = 1'b1;
          stop = 1;
        end
        if (stop) break;
      end
      if (stop) break;
    end
    SPI_MOSI = 1'b0;
    ncyc(2*H);
  endtask

  task automatic check_frame(input int nw);
    chk("rx_count", rx_seen.size(), nw);
    for (int w = 0; w < nw; w++) begin
      chk("miso_word", miso_w[w], exp_w[w]);
      if (rx_seen.size() > 0) chk("rx_word", rx_seen.pop_front(), mosi_w[w]);
    end
    chk("underruns", n_under, exp_under);
    chk("miso_idle", SPI_MISO, 0);
    chk("busy_idle", busy, 0);
    rx_seen.delete();
  endtask

  initial begin
    rst = 1'b1; SPI_CLK = 1'b0; SPI_EN = 1'b1; SPI_MOSI = 1'b0;
    tx_data = '0; tx_valid = 1'b0;
    ncyc(3);
    chk("rst_miso", SPI_MISO, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", tx_underrun, 0);
    rst = 1'b0;
    ncyc(SS + 3);

    // SCLK activity with chip select high
    for (int i = 0; i < 4; i++) begin
      SPI_CLK = 1'b1; ncyc(H);
      SPI_CLK = 1'b0; ncyc(H);
    end
    chk("idle_rx", rx_seen.size(), 0);
    chk("idle_miso", SPI_MISO, 0);
    chk("idle_under", n_under, 0);

    // Single word
    load_tx(8'hA5);
    chk("tx_full", tx_ready, 0);
    mosi_w[0] = 8'h3C;
    frame(1, 0);
    check_frame(1);
    chk("rx_data_3c", rx_data, 8'h3C);
    chk("tx_ready_after", tx_ready, 1);

    // Two-word burst with refill during word 1
    load_tx(8'h81);
    mosi_w[0] = 8'h12; mosi_w[1] = 8'h34;
    fork
      frame(2, 0);
      begin ncyc(30); load_tx(8'h7E); end
    join
    check_frame(2);

    // Empty buffer at frame start
    mosi_w[0] = 8'h5A;
    frame(1, 0);
    check_frame(1);

    // Abort after 5 rising edges
    mosi_w[0] = 8'($urandom);
    frame(1, 5);
    chk("abort_rx", rx_seen.size(), 0);
    chk("abort_rx_data", rx_data, 8'h5A);
    chk("abort_miso", SPI_MISO, 0);
    chk("abort_under", n_under, exp_under);
    load_tx(8'($urandom));
    mosi_w[0] = 8'hC3;
    frame(1, 0);
    check_frame(1);

    // Reset in the middle of a word
    load_tx(8'($urandom));
    void'(model_next());
    SPI_EN = 1'b0; SPI_MOSI = 1'b1;
    ncyc(H); SPI_CLK = 1'b1; ncyc(H); SPI_CLK = 1'b0; ncyc(H); SPI_CLK = 1'b1;
    ncyc(2);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_miso", SPI_MISO, 0);
    chk("mrst_rx_data", rx_data, 0);
    chk("mrst_rx_valid", rx_valid, 0);
    chk("mrst_tx_ready", tx_ready, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_underrun", tx_underrun, 0);
    rst = 1'b0;
    model_txq.delete();
    SPI_CLK = 1'b0;
    ncyc(2*H);
    chk("post_rst_rx", rx_seen.size(), 0);
    chk("post_rst_miso", SPI_MISO, 0);
    SPI_EN = 1'b1;
    ncyc(H);
    load_tx(8'($urandom));
    mosi_w[0] = 8'($urandom);
    frame(1, 0);
    check_frame(1);

    // Randomized frames
    for (int k = 0; k < 5; k++) begin
      int nw;
      nw = int'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) load_tx(8'($urandom));
      for (int w = 0; w < nw; w++) mosi_w[w] = 8'($urandom);
      frame(nw, 0);
      check_frame(nw);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_peripheral.md
# spi_peripheral

SPI responder (mode 0: CPOL=0, CPHA=0, MSB first, SPI_EN active low) forming the far end of the team's SPI master driver. Oversamples the SPI pins on the system clock, shifts in one DATA_WIDTH word per frame from SPI_MOSI while shifting out a preloaded word on SPI_MISO, and supports back-to-back words while SPI_EN stays low. Sits between the pins and a local register/FIFO client. The client uses a valid/ready handshake on transmit and gets a one-cycle strobe on receive.

## Interface
- DATA_WIDTH, 8: bits per word; must be ≥ 2.
- SYNC_STAGES, 2: synchronizer flops per SPI input; must be ≥ 2.
- clk  in  1  system clock; the only clock domain.
- rst  in  1  reset, synchronous and active-high.
- SPI_CLK  in  1  serial clock from the master; idles low.
- SPI_EN  in  1  chip select, active low.
- SPI_MOSI  in  1  serial data from the master.
- SPI_MISO  out  1  serial data to the master; always driven, with no tristate.
- tx_data  in  DATA_WIDTH  next word to return to the master.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  one-entry transmit buffer is empty.
- rx_data  out  DATA_WIDTH  last complete received word; holds until the next word completes.
- rx_valid  out  1  one-cycle strobe: rx_data was updated.
- busy  out  1  high while the synchronized SPI_EN is low.
- tx_underrun  out  1  one-cycle strobe: a word was loaded while the buffer was empty.

## Operation
- Synchronizer inputs pass through SYNC_STAGES flops.
  - Sync flop reset values: SPI_CLK 0, SPI_EN 1, SPI_MOSI 0.
  - Edges are detected by comparing the last sync stage with one extra delay flop: sclk_rise, sclk_fall, en_fall, en_rise.
- Transmit buffer: a one-entry register plus a full flag.
  - tx_ready = !full.
  - The buffer is written when tx_valid && tx_ready.
  - If a load drains the buffer in the same cycle as a write, the new word is accepted and full stays 1.
- FSM states:
  - IDLE: SPI_MISO = 0, bit_cnt = 0.
  - IDLE -> SHIFT on en_fall.
  - SHIFT -> IDLE on en_rise. en_rise takes priority over any same-cycle SCLK edge.
- Word load happens on en_fall, and in SHIFT on the sclk_fall that follows the last bit of a word.
  - shift_tx <= buffer if full, else all-zeros. The all-zeros case pulses tx_underrun.
  - SPI_MISO <= MSB of the loaded word. This makes the first bit valid before the first rising edge.
  - bit_cnt <= 0.
- sclk_rise in SHIFT:
  - shift_rx <= {shift_rx[DATA_WIDTH-2:0], mosi_sync}.
  - bit_cnt <= bit_cnt + 1. The counter is $clog2(DATA_WIDTH) bits wide and wraps to 0 after DATA_WIDTH-1.
  - When bit_cnt == DATA_WIDTH-1: rx_data <= {shift_rx[DATA_WIDTH-2:0], mosi_sync} and rx_valid pulses on the same edge.
- sclk_fall in SHIFT, when not a word boundary: shift_tx shifts left by one and SPI_MISO <= the next bit.
- en_rise mid-word (abort):
  - The partial receive word is discarded with no rx_valid.
  - A partially sent transmit word is not restored.
  - The buffer is untouched.
  - SPI_MISO <= 0.
- SCLK edges seen while SPI_EN is high are ignored.

## Timing
- Reset values: SPI_MISO 0, rx_data 0, rx_valid 0, tx_ready 1, busy 0, tx_underrun 0, state IDLE.
- Pin-to-event latency is SYNC_STAGES+1 clk cycles. rx_valid and rx_data are registered one cycle after the internal edge event.
- SPI_MISO changes SYNC_STAGES+2 clk after a pin SPI_CLK falling edge, or after a pin SPI_EN falling edge.
- Master constraint: each SCLK half-period ≥ SYNC_STAGES+3 clk cycles, and SPI_EN low to the first SCLK rise ≥ SYNC_STAGES+3 clk cycles.
- Reset mid-frame returns to IDLE. The next frame is recognized only after SPI_EN is seen high and then falls again.
- Multi-word burst: the next word is loaded on the falling edge after bit DATA_WIDTH-1. The client has until then to refill the buffer; otherwise 0x00 is sent and tx_underrun pulses.

## Structure
- Package spi_pkg holds the state enum (IDLE, SHIFT) and the CPOL/CPHA mode constants that spi_peripheral shares with the master driver.
- Sub-module spi_sync: a parameterized SYNC_STAGES synchronizer plus rise/fall detect. It is instantiated three times: SPI_CLK, SPI_EN, and SPI_MOSI (MOSI uses level only).
- Top level contains the FSM, the shift registers, the bit counter and the transmit buffer.

## Test plan
- Reset, then idle pins: SPI_MISO=0, tx_ready=1, rx_valid never asserts. Toggle SPI_CLK with SPI_EN high: still no rx_valid.
- Preload 0xA5, then the master sends 0x3C (half-period 6 clk): MISO bits are 1,0,1,0,0,1,0,1. rx_data=0x3C with one rx_valid pulse. tx_ready returns to 1 after en_fall.
- Two-word burst: preload 0x81, refill 0x7E during word 1. Master sends 0x12, 0x34 without releasing SPI_EN. Expect MISO 0x81 then 0x7E, two rx_valid pulses with 0x12 then 0x34, and no tx_underrun.
- Empty buffer at frame start: MISO sends 0x00, tx_underrun pulses once, and the received word is still delivered.
- Abort after 5 rising edges: no rx_valid, rx_data keeps its previous value, SPI_MISO=0. The next full frame with 0xC3 is received correctly.
- Reset asserted mid-word: all outputs go to reset values the next cycle. A subsequent frame after SPI_EN goes high then low completes correctly.
